// File: rtl/apb_regfile_pkg.sv
// rtl/apb_regfile_pkg.sv - shared constants and types for the APB register file slave
package apb_regfile_pkg;

    localparam int NUM_RW_REGS = 14;
    localparam int ADDR_ID     = 14;
    localparam int ADDR_WCNT   = 15;

    localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } phase_t;

endpackage

// File: rtl/apb_wait_gen.sv
// rtl/apb_wait_gen.sv - access-phase wait counter and PREADY generation
//
// Ports:
//   PCLK     bus clock
//   PRESETn  asynchronous active-low reset
//   access   high while the bus is in the access phase (PSEL & PENABLE)
//   pready   transfer-complete indication, low outside the access phase and in reset
module apb_wait_gen #(
    parameter int WAIT_STATES = 0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic access,
    output logic pready
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [3:0] wait_cnt;

    // Clearing on completion as well as outside access lets a setup
    // phase follow immediately with a fresh count.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (!access || pready) begin
            wait_cnt <= '0;
        end else if (wait_cnt < WS) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // PRESETn in the term keeps PREADY low throughout reset even when
    // WAIT_STATES is 0 and the bus is parked in access.
    assign pready = PRESETn & access & (wait_cnt == WS);

endmodule

// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - APB slave with 14 RW registers, an ID register and a write counter
//
// Ports:
//   PCLK     bus clock
//   PRESETn  asynchronous active-low reset
//   PSEL     slave select
//   PENABLE  access-phase indicator
//   PADDR    register index
//   PSTRB    write byte strobes
//   PWDATA   write data
//   PWRITE   1 = write, 0 = read
//   PRDATA   read data, driven only during a read access
//   PREADY   transfer complete / wait-state control
//   PSLVERR  error on writes to the read-only registers
module apb_regfile_slave
    import apb_regfile_pkg::*;
#(
    parameter int         PADDR_SIZE  = 4,
    parameter int         PDATA_SIZE  = 8,
    parameter int         WAIT_STATES = 0,
    parameter logic [7:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic                    PWRITE,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NUM_LANES = PDATA_SIZE / 8;

    phase_t                phase;
    logic                  access;
    logic                  is_rw;
    logic                  is_id;
    logic                  is_wcnt;
    logic                  wr_commit;
    logic [PDATA_SIZE-1:0] regs [NUM_RW_REGS];
    logic [7:0]            wcnt;
    logic [PDATA_SIZE-1:0] rd_data;

    // No protocol checking: PENABLE with PSEL is an access whether or not
    // a setup cycle preceded it.
    always_comb begin
        phase = IDLE;
        if (PSEL) begin
            phase = PENABLE ? ACCESS : SETUP;
        end
    end

    assign access = (phase == ACCESS);

    apb_wait_gen #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_gen (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .access  (access),
        .pready  (PREADY)
    );

    assign is_rw   = (PADDR < PADDR_SIZE'(NUM_RW_REGS));
    assign is_id   = (PADDR == PADDR_SIZE'(ADDR_ID));
    assign is_wcnt = (PADDR == PADDR_SIZE'(ADDR_WCNT));

    // An all-zero strobe write completes cleanly but is not counted.
    assign wr_commit = PREADY & PWRITE & is_rw & (|PSTRB);
    assign PSLVERR   = PREADY & PWRITE & (is_id | is_wcnt);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                regs[i] <= '0;
            end
            wcnt <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                if (PADDR == PADDR_SIZE'(i)) begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (PSTRB[l]) begin
                            regs[i][8*l +: 8] <= PWDATA[8*l +: 8];
                        end
                    end
                end
            end
            wcnt <= wcnt + 8'd1;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (PADDR == PADDR_SIZE'(i)) begin
                rd_data = regs[i];
            end
        end
        if (is_id) begin
            rd_data = PDATA_SIZE'(ID_VALUE);
        end
        if (is_wcnt) begin
            rd_data = PDATA_SIZE'(wcnt);
        end
    end

    assign PRDATA = (PRESETn && access && !PWRITE) ? rd_data : '0;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb/tb_apb_regfile_slave.sv - directed scoreboard bench for apb_regfile_slave
module tb_apb_regfile_slave;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       psel0;
    logic       psel2;
    logic       PENABLE;
    logic [3:0] PADDR;
    logic [0:0] PSTRB;
    logic [7:0] PWDATA;
    logic       PWRITE;

    logic [7:0] prdata0;
    logic       pready0;
    logic       pslverr0;
    logic [7:0] prdata2;
    logic       pready2;
    logic       pslverr2;

    always #5 PCLK = ~PCLK;

    apb_regfile_slave #(
        .PADDR_SIZE  (4),
        .PDATA_SIZE  (8),
        .WAIT_STATES (0),
        .ID_VALUE    (8'hA5)
    ) dut0 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (psel0),
        .PENABLE (PENABLE),
        .PADDR   (PADDR),
        .PSTRB   (PSTRB),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PRDATA  (prdata0),
        .PREADY  (pready0),
        .PSLVERR (pslverr0)
    );

    apb_regfile_slave #(
        .PADDR_SIZE  (4),
        .PDATA_SIZE  (8),
        .WAIT_STATES (2),
        .ID_VALUE    (8'hA5)
    ) dut2 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (psel2),
        .PENABLE (PENABLE),
        .PADDR   (PADDR),
        .PSTRB   (PSTRB),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PRDATA  (prdata2),
        .PREADY  (pready2),
        .PSLVERR (pslverr2)
    );

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       err;
        int         waits;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem  [2][14];
    logic [7:0] wcnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 14; i++) begin
                mem[d][i] = 8'h00;
            end
            wcnt[d] = 8'h00;
        end
    endtask

    function automatic logic [7:0] model_read(input int d, input int a);
        if (a < 14) return mem[d][a];
        if (a == 14) return 8'hA5;
        return wcnt[d];
    endfunction

    // Runs one complete transfer starting at the current time (just after a
    // rising edge) and returns just after the completing edge, so successive
    // calls are back-to-back with no idle cycle.
    task automatic xfer(input int d, input logic wr, input int a, input logic [7:0] wd,
                        input logic st, input string tag);
        exp_t       e;
        exp_t       o;
        int         waits;
        logic       done;
        logic [7:0] got_data;
        logic       got_err;
        e.tag   = tag;
        e.waits = (d == 1) ? 2 : 0;
        e.data  = wr ? 8'h00 : model_read(d, a);
        e.err   = wr && (a >= 14);
        sb.push_back(e);

        PADDR   = 4'(a);
        PWRITE  = wr;
        PWDATA  = wd;
        PSTRB   = st;
        PENABLE = 1'b0;
        psel0   = (d == 0);
        psel2   = (d == 1);
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        waits    = 0;
        done     = 1'b0;
        got_data = 8'h00;
        got_err  = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge PCLK);
            if ((d == 0) ? pready0 : pready2) begin
                got_data = (d == 0) ? prdata0 : prdata2;
                got_err  = (d == 0) ? pslverr0 : pslverr2;
                done     = 1'b1;
            end else begin
                waits++;
            end
        end
        @(posedge PCLK);
        #1;
        psel0   = 1'b0;
        psel2   = 1'b0;
        PENABLE = 1'b0;

        o = sb.pop_front();
        check({o.tag, "_ready"}, 32'(done), 32'd1);
        check({o.tag, "_data"}, 32'(got_data), 32'(o.data));
        check({o.tag, "_err"}, 32'(got_err), 32'(o.err));
        check({o.tag, "_waits"}, 32'(waits), 32'(o.waits));

        if (done && wr && a < 14 && st) begin
            mem[d][a] = wd;
            wcnt[d]   = wcnt[d] + 8'd1;
        end
    endtask

    initial begin
        int n;
        PRESETn = 1'b0;
        psel0   = 1'b1;
        psel2   = 1'b0;
        PENABLE = 1'b1;
        PADDR   = 4'd14;
        PSTRB   = 1'b0;
        PWDATA  = 8'h00;
        PWRITE  = 1'b0;
        model_reset();

        // Bus parked in a read access of the ID register while in reset.
        #12;
        check("rst_pready", 32'(pready0), 32'd0);
        check("rst_pslverr", 32'(pslverr0), 32'd0);
        check("rst_prdata", 32'(prdata0), 32'd0);
        psel0   = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        xfer(0, 1'b0, 3, 8'h00, 1'b0, "rd3_reset");
        xfer(0, 1'b0, 14, 8'h00, 1'b0, "rd_id");

        xfer(0, 1'b1, 5, 8'h3C, 1'b1, "wr5");
        xfer(0, 1'b0, 5, 8'h00, 1'b0, "rd5");
        xfer(0, 1'b0, 15, 8'h00, 1'b0, "rd_wcnt1");

        xfer(0, 1'b1, 14, 8'hFF, 1'b1, "wr_id_err");
        xfer(0, 1'b1, 15, 8'h12, 1'b1, "wr_wcnt_err");
        xfer(0, 1'b0, 14, 8'h00, 1'b0, "rd_id_after");
        xfer(0, 1'b0, 15, 8'h00, 1'b0, "rd_wcnt_after_err");

        xfer(0, 1'b1, 2, 8'hAA, 1'b0, "wr2_nostrb");
        xfer(0, 1'b0, 2, 8'h00, 1'b0, "rd2_nostrb");
        xfer(0, 1'b0, 15, 8'h00, 1'b0, "rd_wcnt_nostrb");

        xfer(1, 1'b1, 5, 8'h5A, 1'b1, "ws_wr5");
        xfer(1, 1'b0, 5, 8'h00, 1'b0, "ws_rd5");

        // Abort a waited write by dropping PSEL after one access cycle.
        PADDR   = 4'd6;
        PWRITE  = 1'b1;
        PWDATA  = 8'h11;
        PSTRB   = 1'b1;
        PENABLE = 1'b0;
        psel2   = 1'b1;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        @(negedge PCLK);
        check("abort_pready", 32'(pready2), 32'd0);
        @(posedge PCLK);
        #1;
        psel2   = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK);
        #1;
        xfer(1, 1'b0, 6, 8'h00, 1'b0, "abort_rd6");
        xfer(1, 1'b0, 15, 8'h00, 1'b0, "abort_wcnt");

        n = 256 - int'(wcnt[0]);
        for (int i = 0; i < n; i++) begin
            xfer(0, 1'b1, i % 14, 8'(i * 7 + 1), 1'b1, "wrap_wr");
        end
        xfer(0, 1'b0, 15, 8'h00, 1'b0, "wcnt_wrap");
        check("wcnt_wrap_zero", 32'(prdata0), 32'd0);
        xfer(0, 1'b0, 9, 8'h00, 1'b0, "rd9_after_wrap");

        xfer(0, 1'b1, 1, 8'h77, 1'b1, "wr1_77");
        xfer(0, 1'b0, 1, 8'h00, 1'b0, "rd1_77");

        // Reset in the middle of an access that would otherwise complete.
        PADDR   = 4'd1;
        PWRITE  = 1'b1;
        PWDATA  = 8'h99;
        PSTRB   = 1'b1;
        PENABLE = 1'b0;
        psel0   = 1'b1;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        @(negedge PCLK);
        check("midrst_pready_before", 32'(pready0), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        check("midrst_pready", 32'(pready0), 32'd0);
        check("midrst_pslverr", 32'(pslverr0), 32'd0);
        psel0   = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        model_reset();
        @(posedge PCLK);
        #1;
        xfer(0, 1'b0, 1, 8'h00, 1'b0, "rd1_after_rst");
        xfer(0, 1'b0, 15, 8'h00, 1'b0, "wcnt_after_rst");
        xfer(1, 1'b0, 5, 8'h00, 1'b0, "ws_rd5_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
